id_ex_stage: RTL and testbench

- ID/EX pipeline stage for the 5-stage MIPS core. It sits directly downstream of the decode control unit and latches the WB[1:0], M[2:0] and EX[4:0] control bundles with the decoded operands.
- Includes load-use hazard detection. On a hazard it stalls PC and IF/ID and inserts a bubble into EX.
- Handles branch flush from MEM and a global pipeline hold.
- Counts inserted bubbles for performance measurement.

---
 rtl/mips_ctrl_pkg.sv | 27 ++
 rtl/hazard_detect_unit.sv | 18 +
 rtl/id_ex_stage.sv | 101 ++++++++++
 tb/tb_id_ex_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Control-bundle layout and ALUOp encodings shared by the MIPS pipeline stages.
package mips_ctrl_pkg;

   localparam int WB_W = 2;
   localparam int M_W  = 3;
   localparam int EX_W = 5;

   localparam int RW_BIT     = 0;
   localparam int M2R_BIT    = 1;
   localparam int BR_BIT     = 0;
   localparam int MRD_BIT    = 1;
   localparam int MWR_BIT    = 2;
   localparam int RDST_BIT   = 0;
   localparam int ALUOP_LSB  = 1;
   localparam int ALUOP_MSB  = 3;
   localparam int ALUSRC_BIT = 4;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_RTYPE = 3'b010,
      ALU_SLT   = 3'b100,
      ALU_AND   = 3'b101,
      ALU_OR    = 3'b111
   } alu_op_e;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard: a valid load in EX writes a register the ID instruction reads.
module hazard_detect_unit #(
   parameter int REG_AW = 5
) (
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic              haz
);

   // $0 is hardwired, so a load targeting it never creates a dependency
   assign haz = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
                ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, global hold
// and a saturating count of hazard bubbles.
module id_ex_stage
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic [WB_W-1:0]   id_wb_i,
   input  logic [M_W-1:0]    id_m_i,
   input  logic [EX_W-1:0]   id_ex_i,
   input  logic [DATA_W-1:0] id_pc4_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              flush_i,
   input  logic              hold_i,
   output logic              ex_valid_o,
   output logic [WB_W-1:0]   ex_wb_o,
   output logic [M_W-1:0]    ex_m_o,
   output logic [EX_W-1:0]   ex_ex_o,
   output logic [DATA_W-1:0] ex_pc4_o,
   output logic [DATA_W-1:0] ex_rs_data_o,
   output logic [DATA_W-1:0] ex_rt_data_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic haz;

   hazard_detect_unit #(.REG_AW(REG_AW)) u_hdu (
      .ex_valid   (ex_valid_o),
      .ex_memread (ex_m_o[MRD_BIT]),
      .ex_rt      (ex_rt_o),
      .id_valid   (id_valid_i),
      .id_rs      (id_rs_i),
      .id_rt      (id_rt_i),
      .haz        (haz)
   );

   // A flush already kills ID, and a hold freezes everything, so neither stalls
   assign stall_o = haz & ~flush_i & ~hold_i & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_o   <= 1'b0;
         ex_wb_o      <= '0;
         ex_m_o       <= '0;
         ex_ex_o      <= '0;
         ex_pc4_o     <= '0;
         ex_rs_data_o <= '0;
         ex_rt_data_o <= '0;
         ex_imm_o     <= '0;
         ex_rs_o      <= '0;
         ex_rt_o      <= '0;
         ex_rd_o      <= '0;
         bubble_cnt_o <= '0;
      end else if (!hold_i) begin
         if (flush_i || haz) begin
            ex_valid_o   <= 1'b0;
            ex_wb_o      <= '0;
            ex_m_o       <= '0;
            ex_ex_o      <= '0;
            ex_pc4_o     <= '0;
            ex_rs_data_o <= '0;
            ex_rt_data_o <= '0;
            ex_imm_o     <= '0;
            ex_rs_o      <= '0;
            ex_rt_o      <= '0;
            ex_rd_o      <= '0;
         end else begin
            ex_valid_o   <= id_valid_i;
            ex_wb_o      <= id_valid_i ? id_wb_i : '0;
            ex_m_o       <= id_valid_i ? id_m_i  : '0;
            ex_ex_o      <= id_valid_i ? id_ex_i : '0;
            ex_pc4_o     <= id_pc4_i;
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_rd_o      <= id_rd_i;
         end
         // Only hazard bubbles are counted; flush bubbles are not
         if (haz && !flush_i && bubble_cnt_o != '1)
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a narrow-counter copy checks saturation.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid_i;
   logic [1:0]  id_wb_i;
   logic [2:0]  id_m_i;
   logic [4:0]  id_ex_i;
   logic [31:0] id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
   logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
   logic        flush_i, hold_i;

   logic        ex_valid_o;
   logic [1:0]  ex_wb_o;
   logic [2:0]  ex_m_o;
   logic [4:0]  ex_ex_o;
   logic [31:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
   logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
   logic        stall_o;
   logic [15:0] bubble_cnt_o;

   logic        s_valid;
   logic [1:0]  s_wb;
   logic [2:0]  s_m;
   logic [4:0]  s_ex;
   logic [31:0] s_pc4, s_rsd, s_rtd, s_imm;
   logic [4:0]  s_rs, s_rt, s_rd;
   logic        s_stall;
   logic [3:0]  s_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_wb_i(id_wb_i),
      .id_m_i(id_m_i), .id_ex_i(id_ex_i), .id_pc4_i(id_pc4_i),
      .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .flush_i(flush_i), .hold_i(hold_i),
      .ex_valid_o(ex_valid_o), .ex_wb_o(ex_wb_o), .ex_m_o(ex_m_o), .ex_ex_o(ex_ex_o),
      .ex_pc4_o(ex_pc4_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
      .ex_imm_o(ex_imm_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
      .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
   );

   id_ex_stage #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_wb_i(id_wb_i),
      .id_m_i(id_m_i), .id_ex_i(id_ex_i), .id_pc4_i(id_pc4_i),
      .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .flush_i(flush_i), .hold_i(hold_i),
      .ex_valid_o(s_valid), .ex_wb_o(s_wb), .ex_m_o(s_m), .ex_ex_o(s_ex),
      .ex_pc4_o(s_pc4), .ex_rs_data_o(s_rsd), .ex_rt_data_o(s_rtd),
      .ex_imm_o(s_imm), .ex_rs_o(s_rs), .ex_rt_o(s_rt), .ex_rd_o(s_rd),
      .stall_o(s_stall), .bubble_cnt_o(s_cnt)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic [1:0] wb, input logic [2:0] m,
                        input logic [4:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] seed);
      id_valid_i   = v;
      id_wb_i      = wb;
      id_m_i       = m;
      id_ex_i      = ex;
      id_rs_i      = rs;
      id_rt_i      = rt;
      id_rd_i      = rd;
      id_pc4_i     = seed;
      id_rs_data_i = seed + 32'h11;
      id_rt_data_i = seed + 32'h22;
      id_imm_i     = seed + 32'h33;
   endtask

   initial begin
      // reset with every input high
      rst = 1'b1; hold_i = 1'b1; flush_i = 1'b1;
      instr(1'b1, '1, '1, '1, '1, '1, '1, '1);
      step(); step();
      check("rst_valid", ex_valid_o, 0);
      check("rst_wb", ex_wb_o, 0);
      check("rst_m", ex_m_o, 0);
      check("rst_ex", ex_ex_o, 0);
      check("rst_pc4", ex_pc4_o, 0);
      check("rst_rsdata", ex_rs_data_o, 0);
      check("rst_rd", ex_rd_o, 0);
      check("rst_stall", stall_o, 0);
      check("rst_cnt", bubble_cnt_o, 0);

      // R-type pass-through
      rst = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
      instr(1'b1, 2'b11, 3'b000, 5'b00101, 5'd8, 5'd9, 5'd10, 32'h100);
      id_rs_data_i = 32'h11;
      #1 check("pt_stall", stall_o, 0);
      step();
      check("pt_valid", ex_valid_o, 1);
      check("pt_wb", ex_wb_o, 2'b11);
      check("pt_m", ex_m_o, 0);
      check("pt_ex", ex_ex_o, 5'b00101);
      check("pt_rs", ex_rs_o, 8);
      check("pt_rt", ex_rt_o, 9);
      check("pt_rd", ex_rd_o, 10);
      check("pt_rsdata", ex_rs_data_o, 32'h11);
      check("pt_rtdata", ex_rt_data_o, 32'h122);
      check("pt_pc4", ex_pc4_o, 32'h100);

      // load-use: lw $8 then add using $8
      instr(1'b1, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd8, 5'd0, 32'h200);
      #1 check("lu_nostall_pre", stall_o, 0);
      step();
      instr(1'b1, 2'b01, 3'b000, 5'b00101, 5'd8, 5'd2, 5'd3, 32'h300);
      #1 check("lu_stall", stall_o, 1);
      step();
      check("lu_bub_valid", ex_valid_o, 0);
      check("lu_bub_wb", ex_wb_o, 0);
      check("lu_bub_m", ex_m_o, 0);
      check("lu_bub_ex", ex_ex_o, 0);
      check("lu_cnt", bubble_cnt_o, 1);
      check("lu_stall_gone", stall_o, 0);
      step();
      check("lu_add_valid", ex_valid_o, 1);
      check("lu_add_rs", ex_rs_o, 8);
      check("lu_add_rd", ex_rd_o, 3);
      check("lu_add_wb", ex_wb_o, 2'b01);

      // load to $0 then use of $0
      instr(1'b1, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd0, 5'd0, 32'h400);
      step();
      instr(1'b1, 2'b01, 3'b000, 5'b00101, 5'd0, 5'd0, 5'd4, 32'h500);
      #1 check("r0_stall", stall_o, 0);
      step();
      check("r0_valid", ex_valid_o, 1);
      check("r0_cnt", bubble_cnt_o, 1);

      // store in EX followed by a reader of its rt
      instr(1'b1, 2'b00, 3'b100, 5'b10000, 5'd1, 5'd5, 5'd0, 32'h600);
      step();
      instr(1'b1, 2'b01, 3'b000, 5'b00101, 5'd5, 5'd6, 5'd7, 32'h700);
      #1 check("st_stall", stall_o, 0);
      step();
      check("st_cnt", bubble_cnt_o, 1);

      // flush while a hazard is present
      instr(1'b1, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd8, 5'd0, 32'h800);
      step();
      instr(1'b1, 2'b01, 3'b000, 5'b00101, 5'd8, 5'd2, 5'd3, 32'h900);
      flush_i = 1'b1;
      #1 check("fl_stall", stall_o, 0);
      step();
      check("fl_valid", ex_valid_o, 0);
      check("fl_m", ex_m_o, 0);
      check("fl_wb", ex_wb_o, 0);
      check("fl_cnt", bubble_cnt_o, 1);
      flush_i = 1'b0;
      step();
      check("fl_after_valid", ex_valid_o, 1);
      check("fl_after_pc4", ex_pc4_o, 32'h900);

      // hold for 3 cycles with a hazard and a flush pending
      instr(1'b1, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd8, 5'd0, 32'hA00);
      step();
      instr(1'b1, 2'b01, 3'b000, 5'b00101, 5'd8, 5'd2, 5'd3, 32'hB00);
      hold_i = 1'b1; flush_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("hd_stall", stall_o, 0);
         step();
         check("hd_valid", ex_valid_o, 1);
         check("hd_m", ex_m_o, 3'b010);
         check("hd_rt", ex_rt_o, 8);
         check("hd_pc4", ex_pc4_o, 32'hA00);
         check("hd_cnt", bubble_cnt_o, 1);
      end
      hold_i = 1'b0; flush_i = 1'b0;
      #1 check("hd_release_stall", stall_o, 1);
      step();
      check("hd_release_valid", ex_valid_o, 0);
      check("hd_release_cnt", bubble_cnt_o, 2);
      step();
      check("hd_add_pc4", ex_pc4_o, 32'hB00);

      // invalid ID slot: controls squashed, data still latched
      instr(1'b0, 2'b11, 3'b010, 5'b11111, 5'd1, 5'd8, 5'd9, 32'hC00);
      step();
      check("inv_valid", ex_valid_o, 0);
      check("inv_wb", ex_wb_o, 0);
      check("inv_m", ex_m_o, 0);
      check("inv_ex", ex_ex_o, 0);
      check("inv_rsdata", ex_rs_data_o, 32'hC11);

      // reset asserted mid-stall
      instr(1'b1, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd8, 5'd0, 32'hD00);
      step();
      instr(1'b1, 2'b01, 3'b000, 5'b00101, 5'd8, 5'd2, 5'd3, 32'hE00);
      #1 check("mr_stall", stall_o, 1);
      rst = 1'b1;
      #1 check("mr_stall_drop", stall_o, 0);
      step();
      check("mr_valid", ex_valid_o, 0);
      check("mr_cnt", bubble_cnt_o, 0);
      check("mr_pc4", ex_pc4_o, 0);
      rst = 1'b0;

      // back-to-back lw $8,0($8): one bubble every other cycle
      instr(1'b1, 2'b11, 3'b010, 5'b10000, 5'd8, 5'd8, 5'd0, 32'hF00);
      for (int i = 0; i < 40; i++) step();
      check("b2b_cnt", bubble_cnt_o, 20);
      check("sat_cnt", s_cnt, 4'hF);
      step(); step();
      check("sat_hold", s_cnt, 4'hF);
      check("b2b_cnt2", bubble_cnt_o, 21);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
